// File: rtl/aria_sl_seq.sv
// ARIA substitution-layer sequencer: applies SL1/SL2 to a 128-bit state by
// time-sharing LANES byte-wide S-box lanes, with valid/ready on both sides.

package aria_sl_pkg;

  // ARIA S2 affine matrix; row i is the input-bit mask for output bit i.
  localparam logic [7:0][7:0] ARIA_B = 64'hCBBA_8134_B9EB_BC7A;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_pow(input logic [7:0] a, input logic [7:0] e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] mat_apply(input logic [7:0][7:0] m, input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = ^(m[i] & x);
    return y;
  endfunction

  // Gauss-Jordan over GF(2); only evaluated at elaboration.
  function automatic logic [7:0][7:0] mat_inv(input logic [7:0][7:0] m);
    logic [7:0][7:0] a;
    logic [7:0][7:0] r;
    logic [7:0]      t;
    int              p;
    a = m;
    for (int i = 0; i < 8; i++) r[i] = 8'h01 << i;
    for (int c = 0; c < 8; c++) begin
      p = c;
      for (int k = 7; k >= c; k--) if (a[k][c]) p = k;
      t = a[c]; a[c] = a[p]; a[p] = t;
      t = r[c]; r[c] = r[p]; r[p] = t;
      for (int k = 0; k < 8; k++) begin
        if (k != c && a[k][c]) begin
          a[k] = a[k] ^ a[c];
          r[k] = r[k] ^ r[c];
        end
      end
    end
    return r;
  endfunction

  localparam logic [7:0][7:0] ARIA_B_INV = mat_inv(ARIA_B);

endpackage

module aria_lt_s1 (
  input  logic [7:0] x,
  output logic [7:0] y
);
  import aria_sl_pkg::*;
  logic [7:0] v;
  assign v = gf_pow(x, 8'd254);
  assign y = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
endmodule

module aria_lt_s1i (
  input  logic [7:0] x,
  output logic [7:0] y
);
  import aria_sl_pkg::*;
  logic [7:0] v;
  logic [7:0] w;
  assign v = x ^ 8'h63;
  assign w = rotl8(v, 1) ^ rotl8(v, 3) ^ rotl8(v, 6);
  assign y = gf_pow(w, 8'd254);
endmodule

module aria_lt_s2 (
  input  logic [7:0] x,
  output logic [7:0] y
);
  import aria_sl_pkg::*;
  assign y = mat_apply(ARIA_B, gf_pow(x, 8'd247)) ^ 8'hE2;
endmodule

module aria_lt_s2i (
  input  logic [7:0] x,
  output logic [7:0] y
);
  import aria_sl_pkg::*;
  // x^247 and x^223 are mutual inverses as exponents mod 255.
  assign y = gf_pow(mat_apply(ARIA_B_INV, x ^ 8'hE2), 8'd223);
endmodule

module aria_sl_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sl_type,
  input  logic [127:0] sl_din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] sl_dout,
  output logic         busy
);

  localparam int N     = 16 / LANES;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int SEG_W = 8 * LANES;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  din_q, din_d;
  logic          type_q, type_d;
  logic [127:0]  res_q, res_d;

  logic [SEG_W-1:0] seg_in;
  logic [SEG_W-1:0] seg_out;
  int               seg_base;

  assign seg_base = SEG_W * (N - 1 - int'(cnt_q));
  assign seg_in   = din_q[seg_base +: SEG_W];

  // Segments start on a multiple of 4 bytes, so lane gi always sees position gi mod 4.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam bit INV_ON_SL1 = (gi % 4) >= 2;
    logic [7:0] lane_in;
    logic [7:0] fwd;
    logic [7:0] inv;

    assign lane_in = seg_in[8*(LANES-1-gi) +: 8];

    if (gi % 2 == 0) begin : g_s1
      aria_lt_s1  u_fwd (.x(lane_in), .y(fwd));
      aria_lt_s1i u_inv (.x(lane_in), .y(inv));
    end else begin : g_s2
      aria_lt_s2  u_fwd (.x(lane_in), .y(fwd));
      aria_lt_s2i u_inv (.x(lane_in), .y(inv));
    end

    assign seg_out[8*(LANES-1-gi) +: 8] = (type_q ^ INV_ON_SL1) ? inv : fwd;
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE) & ~rst;
  assign busy      = (state_q != IDLE) & ~rst;
  assign sl_dout   = res_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    type_d  = type_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          din_d   = sl_din;
          type_d  = sl_type;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d[seg_base +: SEG_W] = seg_out;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      din_q   <= '0;
      type_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      type_q  <= type_d;
      res_q   <= res_d;
    end
  end

endmodule
